// File: rtl/mag_comp_pkg.sv
// -----------------------------------------------------------------------------
// mag_comp_pkg
//   Shared definitions for the minimum-magnitude stream tracker.
//   - state_e      : tracker FSM states (IDLE, ACC, HOLD)
//   - idx_width()  : width of the beat index / beat counter
//   - pass_bits()  : physical width of the payload ports (at least 1)
//   - key_all_ones(): all-ones key of a given width (second-minimum sentinel)
// -----------------------------------------------------------------------------
package mag_comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // The beat counter saturates at MAX_FRAME and that value is also reported
  // as an index, so the field must be able to hold MAX_FRAME itself.
  function automatic int idx_width(input int max_frame);
    return (max_frame < 1) ? 1 : $clog2(max_frame + 1);
  endfunction

  // A zero-width payload still needs a 1-bit port.
  function automatic int pass_bits(input int pass_width);
    return (pass_width > 0) ? pass_width : 1;
  endfunction

  localparam int MAX_KEY_WIDTH = 64;

  function automatic logic [MAX_KEY_WIDTH-1:0] key_all_ones(input int w);
    logic [MAX_KEY_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_KEY_WIDTH; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mag_comp_CLA_nbit_comb_lt.sv
// -----------------------------------------------------------------------------
// mag_comp_CLA_nbit_comb_lt
//   Combinational unsigned "b < a" flag, KEY_WIDTH bits wide.
//   Flattened carry-lookahead form of the original 3-bit cp expression:
//     lt = g[n-1] | e[n-1]&g[n-2] | e[n-1]&e[n-2]&g[n-3] | ...
//   where g[i] = a[i] & ~b[i]  (a wins at bit i)
//         e[i] = ~(a[i] ^ b[i]) (bit i equal)
// Ports:
//   a_i  in  KEY_WIDTH  reference value
//   b_i  in  KEY_WIDTH  candidate value
//   lt_o out 1          1 when b_i < a_i (strict, unsigned)
// -----------------------------------------------------------------------------
module mag_comp_CLA_nbit_comb_lt #(
  parameter int KEY_WIDTH = 3
) (
  input  logic [KEY_WIDTH-1:0] a_i,
  input  logic [KEY_WIDTH-1:0] b_i,
  output logic                 lt_o
);

  logic [KEY_WIDTH-1:0] gen;
  logic [KEY_WIDTH-1:0] eq;

  assign gen = a_i & ~b_i;
  assign eq  = ~(a_i ^ b_i);

  // Each product term: bit i decides in favour of a, all higher bits equal.
  always_comb begin
    logic term;
    lt_o = 1'b0;
    for (int i = 0; i < KEY_WIDTH; i++) begin
      term = gen[i];
      for (int j = i + 1; j < KEY_WIDTH; j++) begin
        term = term & eq[j];
      end
      lt_o = lt_o | term;
    end
  end

endmodule

// File: rtl/mag_comp_min_stream_tracker.sv
// -----------------------------------------------------------------------------
// mag_comp_min_stream_tracker
//   Scans a frame of KEY_WIDTH-bit reliability magnitudes, one per beat, and
//   reports the smallest key, its payload and its beat index (first beat = 0).
//   A new key replaces the current minimum only when strictly smaller, so
//   ties keep the earlier index.
//
//   Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both 1. in_ready is 1 in IDLE/ACC and 0 in HOLD; a
//   result is presented in HOLD with out_valid=1 and stays stable until
//   out_ready is seen, then the block returns to IDLE.
//
//   Optional build macro MAG_COMP_MIN_TRACK_SECOND_MIN_EN adds tracking of the
//   second-smallest entry (out_key2/out_pass2/out_idx2/out_second_vld).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready input beat handshake
//   in_key            magnitude to compare
//   in_pass           payload carried with the key (ignored if PASS_WIDTH=0)
//   in_last           final beat of the frame
//   out_valid/out_ready result handshake
//   out_key/out_pass/out_idx  minimum entry of the frame
//   out_frame_err     frame had more than MAX_FRAME beats
//   out_key2/out_pass2/out_idx2/out_second_vld  second minimum (macro only)
//   dbg_state         current FSM state, for observation
// -----------------------------------------------------------------------------
module mag_comp_min_stream_tracker
  import mag_comp_pkg::*;
#(
  parameter  int KEY_WIDTH  = 3,
  parameter  int PASS_WIDTH = 0,
  parameter  int MAX_FRAME  = 255,
  localparam int PW         = pass_bits(PASS_WIDTH),
  localparam int IDX_WIDTH  = idx_width(MAX_FRAME)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [KEY_WIDTH-1:0] in_key,
  input  logic [PW-1:0]        in_pass,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [KEY_WIDTH-1:0] out_key,
  output logic [PW-1:0]        out_pass,
  output logic [IDX_WIDTH-1:0] out_idx,
  output logic                 out_frame_err,
`ifdef MAG_COMP_MIN_TRACK_SECOND_MIN_EN
  output logic [KEY_WIDTH-1:0] out_key2,
  output logic [PW-1:0]        out_pass2,
  output logic [IDX_WIDTH-1:0] out_idx2,
  output logic                 out_second_vld,
`endif
  output state_e               dbg_state
);

  localparam logic [IDX_WIDTH-1:0] MAX_CNT = IDX_WIDTH'(MAX_FRAME);

  state_e               state_q;
  logic                 valid_q;
  logic [KEY_WIDTH-1:0] key_q;
  logic [PW-1:0]        pass_q;
  logic [IDX_WIDTH-1:0] idx_q;
  logic [IDX_WIDTH-1:0] cnt_q;
  logic [IDX_WIDTH-1:0] cnt_d;
  logic                 err_q;

  logic                 accept;
  logic                 at_max;
  logic                 new_lt_min;
  logic [PW-1:0]        pass_in;

  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid & in_ready;

  // Payload is forced to zero when the design carries none.
  assign pass_in  = (PASS_WIDTH > 0) ? in_pass : '0;

  // Counter saturates: once MAX_FRAME beats are in, later replacements
  // report index MAX_FRAME and the frame is flagged.
  assign at_max   = (cnt_q == MAX_CNT);
  assign cnt_d    = at_max ? cnt_q : cnt_q + IDX_WIDTH'(1);

  mag_comp_CLA_nbit_comb_lt #(
    .KEY_WIDTH(KEY_WIDTH)
  ) u_lt_min (
    .a_i (key_q),
    .b_i (in_key),
    .lt_o(new_lt_min)
  );

`ifdef MAG_COMP_MIN_TRACK_SECOND_MIN_EN
  localparam logic [KEY_WIDTH-1:0] KEY_ONES = KEY_WIDTH'(key_all_ones(KEY_WIDTH));

  logic [KEY_WIDTH-1:0] key2_q;
  logic [PW-1:0]        pass2_q;
  logic [IDX_WIDTH-1:0] idx2_q;
  logic                 svld_q;
  logic                 new_lt_sec;

  mag_comp_CLA_nbit_comb_lt #(
    .KEY_WIDTH(KEY_WIDTH)
  ) u_lt_sec (
    .a_i (key2_q),
    .b_i (in_key),
    .lt_o(new_lt_sec)
  );

  assign out_key2       = key2_q;
  assign out_pass2      = pass2_q;
  assign out_idx2       = idx2_q;
  assign out_second_vld = svld_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      key_q   <= '0;
      pass_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef MAG_COMP_MIN_TRACK_SECOND_MIN_EN
      key2_q  <= '0;
      pass2_q <= '0;
      idx2_q  <= '0;
      svld_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // First beat always becomes the minimum, whatever its value.
          if (accept) begin
            key_q   <= in_key;
            pass_q  <= pass_in;
            idx_q   <= '0;
            cnt_q   <= IDX_WIDTH'(1);
            err_q   <= 1'b0;
`ifdef MAG_COMP_MIN_TRACK_SECOND_MIN_EN
            key2_q  <= KEY_ONES;
            pass2_q <= '0;
            idx2_q  <= '0;
            svld_q  <= 1'b0;
`endif
            if (in_last) begin
              state_q <= HOLD;
              valid_q <= 1'b1;
            end else begin
              state_q <= ACC;
            end
          end
        end

        ACC: begin
          if (accept) begin
            if (new_lt_min) begin
              key_q  <= in_key;
              pass_q <= pass_in;
              idx_q  <= cnt_q;
            end
`ifdef MAG_COMP_MIN_TRACK_SECOND_MIN_EN
            // Displaced minimum drops to second; otherwise a key that only
            // beats the second takes that slot.
            if (new_lt_min) begin
              key2_q  <= key_q;
              pass2_q <= pass_q;
              idx2_q  <= idx_q;
            end else if (new_lt_sec) begin
              key2_q  <= in_key;
              pass2_q <= pass_in;
              idx2_q  <= cnt_q;
            end
            svld_q <= 1'b1;
`endif
            cnt_q <= cnt_d;
            if (at_max) err_q <= 1'b1;
            if (in_last) begin
              state_q <= HOLD;
              valid_q <= 1'b1;
            end
          end
        end

        HOLD: begin
          if (out_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid     = valid_q;
  assign out_key       = key_q;
  assign out_pass      = pass_q;
  assign out_idx       = idx_q;
  assign out_frame_err = err_q;
  assign dbg_state     = state_q;

endmodule
